uart_rx_controller: RTL and testbench
=====================================

Name: uart_rx_controller

Overview:
- Receive-path sequencer for the UART receiver.
- Detects the start bit and runs the edge/bit counters that time the data sampler (edge_count, sampler_enable).
- Consumes the sampler's majority-voted bit, deserializes LSB-first, checks parity and stop bits, and presents a parallel byte with a one-cycle valid strobe.
- Sits between the serial pin and the receiver's output register/FIFO.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- clk  input  1  receiver oversampling clock (prescale edges per bit).
- reset  input  1  synchronous, active-high reset.
- serial_data_in  input  1  RX line, idle high; already synchronized upstream.
- prescale  input  5  oversampling ratio; legal values 8..31; latched at start-bit detection.
- parity_enable  input  1  1 = frame carries a parity bit; latched at start-bit detection.
- parity_type  input  1  0 = even, 1 = odd; latched at start-bit detection.
- sampled_bit  input  1  majority-voted bit from the data sampler; valid when edge_count == prescale_q-1.
- sampler_enable  output  1  enables the data sampler; high in every state except IDLE.
- edge_count  output  5  oversampling edge index within the current bit, 0..prescale_q-1.
- parallel_data  output  DATA_WIDTH  received word; holds its value until the next good frame.
- data_valid  output  1  one-cycle pulse when a frame passes both the parity and stop checks.
- parity_error  output  1  one-cycle pulse at the end of the parity bit on mismatch.
- frame_error  output  1  one-cycle pulse at the end of the stop bit if the stop bit is 0.

Behaviour:
- Reset (synchronous, priority over all other logic):
  - state=IDLE; edge_count=0; bit_index=0; shift register=0.
  - parallel_data=0.
  - data_valid, parity_error, frame_error, sampler_enable = 0.
- A bit period ends at edge E = prescale_q-1.
  - edge_count increments every cycle outside IDLE and wraps E -> 0.
  - sampled_bit is evaluated only at edge E.
- States:
  - IDLE:
    - edge_count held at 0.
    - serial_data_in==0 -> latch prescale_q, parity_enable_q, parity_type_q; go to START.
  - START:
    - At E, sampled_bit==1 -> glitch: return to IDLE; no error flags, no output change.
    - At E, sampled_bit==0 -> go to DATA with bit_index=0.
  - DATA:
    - At E, shift sampled_bit into the MSB of the shift register (LSB-first line order) and increment bit_index.
    - After DATA_WIDTH bits -> go to PARITY if parity_enable_q, else STOP.
  - PARITY:
    - At E, compute expected = XOR(data) XOR parity_type_q.
    - Store mismatch = (sampled_bit != expected); pulse parity_error on the next cycle if mismatch.
    - Go to STOP.
  - STOP:
    - At E, if sampled_bit==0, pulse frame_error.
    - Else, if no stored parity mismatch, load parallel_data and pulse data_valid.
    - Go to IDLE in all cases.
- Latency: data_valid asserts 1 cycle after the stop-bit edge E (registered outputs).
- Back-to-back frames:
  - A line low on the first IDLE cycle after STOP is accepted as a new start bit.
  - No dead cycle is required beyond the one IDLE cycle.
- prescale, parity_enable and parity_type changes mid-frame are ignored until the next start detection.
- Simultaneous parity and stop errors:
  - Both flags pulse, each on its own cycle.
  - data_valid is not asserted.
  - parallel_data is unchanged.
- An illegal prescale (<8) gives undefined sampling but must still return to IDLE; no lockup.
- Width rules:
  - edge_count and the E comparison are 5-bit unsigned.
  - bit_index is $clog2(DATA_WIDTH+1) bits.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - PARITY_EVEN/PARITY_ODD constants;
  - MIN_PRESCALE=8.
- Sub-module uart_rx_edge_bit_counter holds edge_count, bit_index and the wrap/"end of bit" strobe.
- The FSM, deserializer and checks stay in uart_rx_controller.

Test Plan:
- prescale=8, parity off, line sends 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> parallel_data=0xA5, data_valid one pulse at cycle 80 after the falling edge; no error flags.
- prescale=16, even parity, byte 0x37 with correct parity bit 1 -> data_valid, parallel_data=0x37. Repeat with parity bit 0 -> parity_error pulse, no data_valid, parallel_data still 0x37.
- Start glitch: line low for 3 cycles at prescale=8 so the sampler votes 1 -> FSM back to IDLE after 8 cycles; no outputs change; a subsequent valid frame 0x5A is received correctly.
- Stop bit forced 0 on byte 0xFF, parity off -> frame_error pulse, data_valid low, parallel_data unchanged.
- Two back-to-back frames 0x01, 0x80 at prescale=8 with the second start bit immediately after the stop bit -> two data_valid pulses with the matching values.
- Reset asserted during DATA bit 4, then released -> all outputs 0, state IDLE, edge_count 0; the next frame 0xC3 is received correctly.
- prescale changed from 8 to 16 mid-frame -> the current frame still times at 8; the next frame times at 16.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state codes and constants for the UART receive path
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic [4:0] MIN_PRESCALE = 5'd8;

    // Last oversampling edge of a bit; prescale 0 wraps to 31 so the counter never stalls.
    function automatic logic [4:0] last_edge(input logic [4:0] prescale);
        return prescale - 5'd1;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversampling edge counter, bit index and end-of-bit strobe
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               active,
    input  logic [4:0]                         prescale_q,
    input  logic                               bit_clear,
    input  logic                               bit_inc,
    output logic [4:0]                         edge_count,
    output logic [$clog2(DATA_WIDTH+1)-1:0]    bit_index,
    output logic                               bit_end
);

    assign bit_end = active && (edge_count == last_edge(prescale_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_count <= 5'd0;
        end else if (!active || bit_end) begin
            edge_count <= 5'd0;
        end else begin
            edge_count <= edge_count + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bit_clear) begin
            bit_index <= '0;
        end else if (bit_inc) begin
            bit_index <= bit_index + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// rtl/uart_rx_controller.sv - UART receive sequencer: start detect, deserialize, parity and stop checks
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_data_in,
    input  logic [4:0]            prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  sampled_bit,
    output logic                  sampler_enable,
    output logic [4:0]            edge_count,
    output logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  frame_error
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [4:0]            prescale_q;
    logic                  parity_enable_q;
    logic                  parity_type_q;
    logic                  parity_bad;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BW-1:0]         bit_index;
    logic                  bit_end;
    logic                  parity_expected;

    assign sampler_enable  = (state != ST_IDLE);
    assign parity_expected = (^shift_reg) ^ (parity_type_q == PARITY_ODD);

    uart_rx_edge_bit_counter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .active     (sampler_enable),
        .prescale_q (prescale_q),
        .bit_clear  (state == ST_START),
        .bit_inc    ((state == ST_DATA) && bit_end),
        .edge_count (edge_count),
        .bit_index  (bit_index),
        .bit_end    (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            prescale_q      <= MIN_PRESCALE;
            parity_enable_q <= 1'b0;
            parity_type_q   <= PARITY_EVEN;
            parity_bad      <= 1'b0;
            shift_reg       <= '0;
            parallel_data   <= '0;
            data_valid      <= 1'b0;
            parity_error    <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!serial_data_in) begin
                        prescale_q      <= prescale;
                        parity_enable_q <= parity_enable;
                        parity_type_q   <= parity_type;
                        parity_bad      <= 1'b0;
                        state           <= ST_START;
                    end
                end
                ST_START: begin
                    // A start bit the sampler votes high was a glitch: drop it silently.
                    if (bit_end) begin
                        state <= sampled_bit ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                        if (bit_index == LAST_BIT) begin
                            state <= parity_enable_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        parity_bad   <= (sampled_bit != parity_expected);
                        parity_error <= (sampled_bit != parity_expected);
                        state        <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (!sampled_bit) begin
                            frame_error <= 1'b1;
                        end else if (!parity_bad) begin
                            parallel_data <= shift_reg;
                            data_valid    <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb/tb_uart_rx_controller.sv - randomized and directed frame bench for uart_rx_controller
module tb_uart_rx_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_data_in;
    logic [4:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic       sampled_bit;
    logic       sampler_enable;
    logic [4:0] edge_count;
    logic [7:0] parallel_data;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;

    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;
    logic [7:0] last_good = 8'h00;

    int         dv_cyc[$];
    logic [7:0] dv_dat[$];
    int         pe_cyc[$];
    int         fe_cyc[$];
    int         exp_dv_cyc[$];
    logic [7:0] exp_dv_dat[$];
    int         exp_pe_cyc[$];
    int         exp_fe_cyc[$];

    uart_rx_controller #(.DATA_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_data_in (serial_data_in),
        .prescale       (prescale),
        .parity_enable  (parity_enable),
        .parity_type    (parity_type),
        .sampled_bit    (sampled_bit),
        .sampler_enable (sampler_enable),
        .edge_count     (edge_count),
        .parallel_data  (parallel_data),
        .data_valid     (data_valid),
        .parity_error   (parity_error),
        .frame_error    (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (data_valid) begin
            dv_cyc.push_back(ncyc);
            dv_dat.push_back(parallel_data);
        end
        if (parity_error) pe_cyc.push_back(ncyc);
        if (frame_error)  fe_cyc.push_back(ncyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        serial_data_in = 1'b1;
        sampled_bit    = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sampler model: its vote for bit k is presented one cycle behind the line, so it is stable at that bit's last edge.
    task automatic send_frame(input int p, input logic [7:0] data, input bit pen, input bit ptype,
                              input bit bad_par, input bit bad_stop, input int p_mid, input int abort_at);
        logic [11:0] fb;
        int nb;
        int n0;
        nb = pen ? 11 : 10;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = data[i];
        if (pen) fb[9] = (^data) ^ ptype ^ bad_par;
        fb[nb-1] = ~bad_stop;
        prescale      = 5'(p);
        parity_enable = pen;
        parity_type   = ptype;
        n0 = ncyc;
        for (int c = 0; c <= nb * p; c++) begin
            if (c == abort_at) return;
            serial_data_in = (c / p < nb) ? fb[c / p] : 1'b1;
            sampled_bit    = (c == 0) ? 1'b1 : fb[(c - 1) / p];
            if (p_mid != 0 && c == 20) prescale = 5'(p_mid);
            @(posedge clk);
            #1;
        end
        if (pen && bad_par) exp_pe_cyc.push_back(n0 + (nb - 1) * p + 2);
        if (bad_stop) begin
            exp_fe_cyc.push_back(n0 + nb * p + 2);
        end else if (!(pen && bad_par)) begin
            exp_dv_cyc.push_back(n0 + nb * p + 2);
            exp_dv_dat.push_back(data);
            last_good = data;
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_dv_count"}, dv_cyc.size(), exp_dv_cyc.size());
        check({tag, "_pe_count"}, pe_cyc.size(), exp_pe_cyc.size());
        check({tag, "_fe_count"}, fe_cyc.size(), exp_fe_cyc.size());
        for (int i = 0; i < dv_cyc.size() && i < exp_dv_cyc.size(); i++) begin
            check({tag, "_dv_cycle"}, dv_cyc[i], exp_dv_cyc[i]);
            check({tag, "_dv_data"}, {24'd0, dv_dat[i]}, {24'd0, exp_dv_dat[i]});
        end
        for (int i = 0; i < pe_cyc.size() && i < exp_pe_cyc.size(); i++)
            check({tag, "_pe_cycle"}, pe_cyc[i], exp_pe_cyc[i]);
        for (int i = 0; i < fe_cyc.size() && i < exp_fe_cyc.size(); i++)
            check({tag, "_fe_cycle"}, fe_cyc[i], exp_fe_cyc[i]);
        dv_cyc.delete(); dv_dat.delete(); pe_cyc.delete(); fe_cyc.delete();
        exp_dv_cyc.delete(); exp_dv_dat.delete(); exp_pe_cyc.delete(); exp_fe_cyc.delete();
    endtask

    task automatic settle(input string tag);
        idle(3);
        drain(tag);
        check({tag, "_parallel_data"}, {24'd0, parallel_data}, {24'd0, last_good});
        check({tag, "_idle_edge_count"}, {27'd0, edge_count}, 32'd0);
        check({tag, "_idle_sampler_en"}, {31'd0, sampler_enable}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_parallel_data"}, {24'd0, parallel_data}, 32'd0);
        check({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_parity_error"}, {31'd0, parity_error}, 32'd0);
        check({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
        check({tag, "_sampler_en"}, {31'd0, sampler_enable}, 32'd0);
        check({tag, "_edge_count"}, {27'd0, edge_count}, 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        serial_data_in = 1'b1;
        sampled_bit    = 1'b1;
        prescale       = 5'd8;
        parity_enable  = 1'b0;
        parity_type    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        idle(2);

        send_frame(8, 8'hA5, 0, 0, 0, 0, 0, -1);
        settle("a5_p8");

        send_frame(16, 8'h37, 1, 0, 0, 0, 0, -1);
        settle("37_even_ok");
        send_frame(16, 8'h37, 1, 0, 1, 0, 0, -1);
        settle("37_even_bad");

        // Start glitch: line low 3 cycles, sampler votes high.
        prescale = 5'd8;
        for (int c = 0; c <= 9; c++) begin
            serial_data_in = (c < 3) ? 1'b0 : 1'b1;
            sampled_bit    = 1'b1;
            @(posedge clk);
            #1;
        end
        settle("glitch");
        send_frame(8, 8'h5A, 0, 0, 0, 0, 0, -1);
        settle("5a_after_glitch");

        send_frame(8, 8'hFF, 0, 0, 0, 1, 0, -1);
        settle("ff_stop0");

        send_frame(8, 8'h01, 0, 0, 0, 0, 0, -1);
        send_frame(8, 8'h80, 0, 0, 0, 0, 0, -1);
        settle("back_to_back");

        send_frame(12, 8'h37, 1, 1, 1, 1, 0, -1);
        settle("par_and_stop_err");

        send_frame(8, 8'h3C, 0, 0, 0, 0, 0, 8 * 5 + 3);
        reset = 1'b1;
        serial_data_in = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_reset");
        reset = 1'b0;
        last_good = 8'h00;
        idle(2);
        send_frame(8, 8'hC3, 0, 0, 0, 0, 0, -1);
        settle("c3_after_reset");

        send_frame(8, 8'h6E, 0, 0, 0, 0, 16, -1);
        settle("prescale_mid_change");
        send_frame(16, 8'h91, 0, 0, 0, 0, 0, -1);
        settle("prescale_next_frame");

        for (int n = 0; n < 25; n++) begin
            send_frame(int'($urandom_range(8, 31)), 8'($urandom), bit'($urandom_range(0, 1)),
                       bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) == 0), 0, -1);
            settle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
